seg7_scan_driver: RTL and testbench

//  Time-multiplexed N-digit seven-segment display driver with hex decode, per-digit dot and blank,
//  and PWM brightness control. Replaces hand-rolled digit traversal logic next to the board pins.

---
 rtl/seg7_scan_driver.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_driver                                              |
// | Purpose  : Time-multiplexed N-digit seven-segment driver. Hex decode,    |
// |            per-digit dot and blank, PWM brightness. New content goes     |
// |            into shadow (pending) registers and is copied to the active   |
// |            set only at a frame boundary, so a frame never tears.         |
// | Ports    : CLK100_IN      - system clock                                 |
// |            rst_n          - asynchronous active-low reset                |
// |            DATA_IN        - hex nibble per digit, digit 0 = rightmost    |
// |            DOT_IN         - decimal point per digit (1 = lit)            |
// |            BLANK_IN       - blank per digit (1 = dark)                   |
// |            BRIGHT_IN      - lit slots per digit dwell, 0 = dark          |
// |            LOAD_IN        - strobe, captures the four inputs above       |
// |            SEG_SELECT_OUT - anode enables, active-low, one-cold or none  |
// |            HEX_OUT        - {dp,g,f,e,d,c,b,a}, active-low               |
// |            FRAME_DONE_OUT - one-cycle pulse after the last frame slot    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 1562,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    CLK100_IN,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] DATA_IN,
  input  logic [NUM_DIGITS-1:0]   DOT_IN,
  input  logic [NUM_DIGITS-1:0]   BLANK_IN,
  input  logic [BRIGHT_W-1:0]     BRIGHT_IN,
  input  logic                    LOAD_IN,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    FRAME_DONE_OUT
);

  localparam int c_SC_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int c_DG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_SC_W-1:0] c_SLOT_LAST  = c_SC_W'(SLOT_CYC - 1);
  localparam logic [c_DG_W-1:0] c_DIGIT_LAST = c_DG_W'(NUM_DIGITS - 1);

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (SLOT_CYC < 1) begin : g_bad_slot_cyc
    $error("seg7_scan_driver: SLOT_CYC must be >= 1");
  end

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] f_seg7_n(input logic [3:0] i_nib);
    case (i_nib)
      4'h0: f_seg7_n = 7'h40;
      4'h1: f_seg7_n = 7'h79;
      4'h2: f_seg7_n = 7'h24;
      4'h3: f_seg7_n = 7'h30;
      4'h4: f_seg7_n = 7'h19;
      4'h5: f_seg7_n = 7'h12;
      4'h6: f_seg7_n = 7'h02;
      4'h7: f_seg7_n = 7'h78;
      4'h8: f_seg7_n = 7'h00;
      4'h9: f_seg7_n = 7'h10;
      4'hA: f_seg7_n = 7'h08;
      4'hB: f_seg7_n = 7'h03;
      4'hC: f_seg7_n = 7'h46;
      4'hD: f_seg7_n = 7'h21;
      4'hE: f_seg7_n = 7'h06;
      default: f_seg7_n = 7'h0E;
    endcase
  endfunction

  // Scan counters
  logic [c_SC_W-1:0]   r_slot_cnt;
  logic [BRIGHT_W-1:0] r_slot_idx;
  logic [c_DG_W-1:0]   r_digit_idx;

  // Shadow and active display content
  logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
  logic [NUM_DIGITS-1:0]   r_pend_dot, r_act_dot;
  logic [NUM_DIGITS-1:0]   r_pend_blank, r_act_blank;
  logic [BRIGHT_W-1:0]     r_pend_bright, r_act_bright;

  // Registered outputs
  logic [NUM_DIGITS-1:0] r_sel;
  logic [7:0]            r_hex;
  logic                  r_frame_done;

  logic                  w_slot_end;
  logic                  w_dwell_end;
  logic                  w_fb;
  logic                  w_lit;
  logic [3:0]            w_nibble;
  logic                  w_dot;
  logic                  w_digit_blank;
  logic [NUM_DIGITS-1:0] w_onehot;

  assign w_slot_end  = (r_slot_cnt == c_SLOT_LAST);
  assign w_dwell_end = w_slot_end && (r_slot_idx == {BRIGHT_W{1'b1}});
  assign w_fb        = w_dwell_end && (r_digit_idx == c_DIGIT_LAST);

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt  <= '0;
      r_slot_idx  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_end) begin
      r_slot_cnt <= '0;
      // slot_idx spans the full 2**BRIGHT_W range, so it wraps on its own.
      r_slot_idx <= r_slot_idx + BRIGHT_W'(1);
      if (w_dwell_end) begin
        r_digit_idx <= (r_digit_idx == c_DIGIT_LAST) ? '0 : r_digit_idx + c_DG_W'(1);
      end
    end else begin
      r_slot_cnt <= r_slot_cnt + c_SC_W'(1);
    end
  end

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data   <= '0;
      r_pend_dot    <= '0;
      r_pend_blank  <= '1;
      r_pend_bright <= '0;
    end else if (LOAD_IN) begin
      r_pend_data   <= DATA_IN;
      r_pend_dot    <= DOT_IN;
      r_pend_blank  <= BLANK_IN;
      r_pend_bright <= BRIGHT_IN;
    end
  end

  // A load landing on the boundary cycle bypasses the shadow so it is not
  // delayed by a whole frame.
  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_act_data   <= '0;
      r_act_dot    <= '0;
      r_act_blank  <= '1;
      r_act_bright <= '0;
    end else if (w_fb) begin
      r_act_data   <= LOAD_IN ? DATA_IN   : r_pend_data;
      r_act_dot    <= LOAD_IN ? DOT_IN    : r_pend_dot;
      r_act_blank  <= LOAD_IN ? BLANK_IN  : r_pend_blank;
      r_act_bright <= LOAD_IN ? BRIGHT_IN : r_pend_bright;
    end
  end

  // Per-digit field select; a loop mux keeps widths exact for any digit count.
  always_comb begin
    w_nibble      = '0;
    w_dot         = 1'b0;
    w_digit_blank = 1'b1;
    w_onehot      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_digit_idx == c_DG_W'(k)) begin
        w_nibble      = r_act_data[4*k +: 4];
        w_dot         = r_act_dot[k];
        w_digit_blank = r_act_blank[k];
        w_onehot[k]   = 1'b1;
      end
    end
  end

  // slot_idx never reaches 2**BRIGHT_W, so the final slot of each dwell is
  // always dark and acts as the inter-digit ghosting guard.
  assign w_lit = (r_slot_idx < r_act_bright) && !w_digit_blank;

  always_ff @(posedge CLK100_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= '1;
      r_hex        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_fb;
      if (w_lit) begin
        r_sel <= ~w_onehot;
        r_hex <= {~w_dot, f_seg7_n(w_nibble)};
      end else begin
        r_sel <= '1;
        r_hex <= 8'hFF;
      end
    end
  end

  assign SEG_SELECT_OUT = r_sel;
  assign HEX_OUT        = r_hex;
  assign FRAME_DONE_OUT = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_driver                                           |
// | Purpose  : Scoreboard bench for seg7_scan_driver with 4 digits, 2-cycle  |
// |            slots and 2-bit brightness (8-cycle dwell, 32-cycle frame).   |
// |            Per-digit segment bytes are entered by hand in each config.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seg7_scan_driver;

  localparam int NUM_DIGITS = 4;
  localparam int SLOT_CYC   = 2;
  localparam int BRIGHT_W   = 2;
  localparam int c_FRAME    = 32;

  logic        CLK100_IN = 1'b0;
  logic        rst_n     = 1'b1;
  logic [15:0] DATA_IN   = '0;
  logic [3:0]  DOT_IN    = '0;
  logic [3:0]  BLANK_IN  = '0;
  logic [1:0]  BRIGHT_IN = '0;
  logic        LOAD_IN   = 1'b0;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;
  logic        FRAME_DONE_OUT;

  seg7_scan_driver #(
    .NUM_DIGITS(NUM_DIGITS),
    .SLOT_CYC  (SLOT_CYC),
    .BRIGHT_W  (BRIGHT_W)
  ) u_dut (
    .CLK100_IN     (CLK100_IN),
    .rst_n         (rst_n),
    .DATA_IN       (DATA_IN),
    .DOT_IN        (DOT_IN),
    .BLANK_IN      (BLANK_IN),
    .BRIGHT_IN     (BRIGHT_IN),
    .LOAD_IN       (LOAD_IN),
    .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .HEX_OUT       (HEX_OUT),
    .FRAME_DONE_OUT(FRAME_DONE_OUT)
  );

  always #5 CLK100_IN = ~CLK100_IN;

  // hx holds the hand-computed HEX_OUT byte of digit d at hx[8*d +: 8].
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dot;
    logic [3:0]  blank;
    logic [1:0]  bright;
    logic [31:0] hx;
  } cfg_t;

  localparam cfg_t c_DARK  = '{16'h0000, 4'b0000, 4'b1111, 2'd0, 32'hFFFFFFFF};
  localparam cfg_t c_CFG_A = '{16'hCA80, 4'b1010, 4'b0000, 2'd3, 32'h468800C0};
  localparam cfg_t c_CFG_B = '{16'hCA80, 4'b1010, 4'b0000, 2'd1, 32'h468800C0};
  localparam cfg_t c_CFG_C = '{16'hCA80, 4'b1010, 4'b0000, 2'd0, 32'h468800C0};
  localparam cfg_t c_CFG_D = '{16'h1234, 4'b0001, 4'b0000, 2'd2, 32'hF9A4B019};
  localparam cfg_t c_CFG_E = '{16'h5F7E, 4'b0000, 4'b0100, 2'd3, 32'h928EF886};
  localparam cfg_t c_CFG_F = '{16'h9BD6, 4'b0000, 4'b0000, 2'd3, 32'h9083A182};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  cfg_t cur    = c_DARK;
  cfg_t pend   = c_DARK;
  logic [12:0] sb_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endfunction

  // Monitor: outputs are valid every cycle, one expectation per cycle.
  always @(negedge CLK100_IN) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow cyc=%0d actual=empty expected=entry", cyc);
      end else begin
        logic [12:0] e;
        e = sb_q.pop_front();
        chk("scan{sel,hex,fd}", {19'd0, SEG_SELECT_OUT, HEX_OUT, FRAME_DONE_OUT}, {19'd0, e});
      end
    end
  end

  // One clock of stimulus: queue the output the current counter state must
  // produce one cycle later, optionally load a config, then advance.
  task automatic step(input bit ld, input cfg_t c);
    int p, d, s;
    bit lit;
    logic [3:0] one;
    p   = cyc % c_FRAME;
    d   = p / 8;
    s   = (p % 8) / 2;
    lit = (s < int'(cur.bright)) && !cur.blank[d];
    one = 4'b0001;
    one = one << d;
    sb_q.push_back({lit ? ~one : 4'hF, lit ? cur.hx[8*d +: 8] : 8'hFF, (p == c_FRAME - 1)});
    if (ld) begin
      DATA_IN   = c.data;
      DOT_IN    = c.dot;
      BLANK_IN  = c.blank;
      BRIGHT_IN = c.bright;
      LOAD_IN   = 1'b1;
      pend      = c;
    end
    if (p == c_FRAME - 1) cur = pend;
    @(posedge CLK100_IN);
    #1;
    LOAD_IN   = 1'b0;
    DATA_IN   = 16'hDEAD;
    DOT_IN    = 4'hF;
    BLANK_IN  = 4'h0;
    BRIGHT_IN = 2'd3;
    cyc++;
    mon_en = 1'b1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step(1'b0, c_DARK);
  endtask

  task automatic load_at(input int target, input cfg_t c);
    run_to(target);
    step(1'b1, c);
  endtask

  task automatic release_reset();
    @(negedge CLK100_IN);
    rst_n = 1'b1;
    cyc   = 0;
    cur   = c_DARK;
    pend  = c_DARK;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel", {28'd0, SEG_SELECT_OUT}, 32'hF);
    chk("rst_hex", {24'd0, HEX_OUT}, 32'hFF);
    chk("rst_fd", {31'd0, FRAME_DONE_OUT}, 32'd0);
    repeat (2) @(posedge CLK100_IN);
    #1;
    chk("rst_hold_sel", {28'd0, SEG_SELECT_OUT}, 32'hF);
    release_reset();

    // Three dark frames, then the content sequence.
    load_at(3*c_FRAME + 10, c_CFG_A);   // mid-frame load -> frame 4
    load_at(4*c_FRAME + 31, c_CFG_B);   // load on boundary -> frame 5
    load_at(5*c_FRAME + 10, c_CFG_C);   // BRIGHT 0 -> frame 6 dark
    load_at(6*c_FRAME + 3,  c_CFG_D);   // overwritten below
    load_at(6*c_FRAME + 20, c_CFG_E);   // last load wins -> frame 7
    load_at(7*c_FRAME + 0,  c_CFG_D);   // -> frame 8
    load_at(8*c_FRAME + 12, c_CFG_F);   // -> frame 9
    run_to(9*c_FRAME + 19);

    // Output now shows digit 2, slot 1 of config F.
    chk("pre_rst_sel", {28'd0, SEG_SELECT_OUT}, 32'hB);
    chk("pre_rst_hex", {24'd0, HEX_OUT}, 32'h83);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_sel", {28'd0, SEG_SELECT_OUT}, 32'hF);
    chk("async_rst_hex", {24'd0, HEX_OUT}, 32'hFF);
    chk("async_rst_fd", {31'd0, FRAME_DONE_OUT}, 32'd0);
    sb_q.delete();
    repeat (3) @(posedge CLK100_IN);
    #1;
    chk("rst_hold_hex", {24'd0, HEX_OUT}, 32'hFF);
    release_reset();

    // After reset: dark first frame, scan resumes at digit 0.
    load_at(5, c_CFG_A);
    run_to(2*c_FRAME + 1);
    @(negedge CLK100_IN);
    #1;
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
